hazard3_sync_fifo: RTL and testbench
====================================

# hazard3_sync_fifo

Parametrised single-clock FIFO with valid/ready handshake on both sides, a fill-level output, almost-full and almost-empty thresholds, and synchronous flush. An optional registered read-data stage cuts the memory-to-consumer path. It is the general-purpose buffer for debug transport, bus bridges and trace paths. It replaces ad-hoc minimal FIFOs that offer only full/empty.

## Interface
- `WIDTH`, default 8: data width in bits, at least 1.
- `LOG_DEPTH`, default 2: memory depth is `DEPTH = 2**LOG_DEPTH`, with LOG_DEPTH at least 1.
- `REG_OUT`, default 0: 1 adds a registered output stage. Capacity then becomes DEPTH+1.
- `AFULL_LEVEL`, default DEPTH-1: `afull` asserts when level ≥ AFULL_LEVEL.
- `AEMPTY_LEVEL`, default 1: `aempty` asserts when level ≤ AEMPTY_LEVEL.
- Ports:
  - `clk` in 1: clock.
  - `rst_n` in 1: reset, asynchronous, active-low.
  - `flush` in 1: synchronous clear of all contents.
  - `wdata` in WIDTH: write data.
  - `wvld` in 1: write valid.
  - `wrdy` out 1: space available.
  - `rdata` out WIDTH: head-of-queue data.
  - `rvld` out 1: head valid.
  - `rrdy` in 1: consumer accepts head.
  - `level` out LOG_DEPTH+1: current entry count. For REG_OUT=1 and LOG_DEPTH=1 the maximum is 3, so the width is `$clog2(CAP+1)`. The implementation uses that width, named `LW`.
  - `full` out 1: level == capacity.
  - `empty` out 1: level == 0.
  - `afull` out 1.
  - `aempty` out 1.

## Operation
- **Pointers:** read and write pointers are LOG_DEPTH+1 bits. The MSB is the wrap bit.
  - Memory full means the pointers are equal except for the MSB.
  - Memory empty means the pointers are equal.
- **Write:** a write is accepted when `wvld && wrdy`. `wrdy = !full`, computed combinationally from registered state only. `wrdy` never depends on `rrdy`, so there is no write-through when full.
- **Read:** a read is accepted when `rvld && rrdy`. `rvld = !empty`. `rdata` holds its value while `rvld && !rrdy`.
- **REG_OUT=0:** `rdata` is the memory word at the read pointer.
- **REG_OUT=1:** an output register holds the head word with flag `ov`.
  - The register loads from memory when memory is non-empty and either `!ov` or the head is being accepted this cycle.
  - `level` = memory count + `ov`.
- **Level:** the level counter updates +1 on a write only, −1 on a read only, and is unchanged on a simultaneous write and read. `full`, `empty`, `afull` and `aempty` are decoded from the registered level and pointers, never from inputs.
- **Simultaneous write and read when full:** only the read is accepted, because `wrdy` = 0. When empty, only the write is accepted.
- **Flush:**
  - Next cycle, pointers, level and `ov` are 0.
  - A write or read handshake in the flush cycle is discarded, and level does not count it.
  - Memory contents are not cleared.
- **Reset:** all outputs are defined at reset.
  - `wrdy` = 1, `rvld` = 0, `level` = 0.
  - `full` = 0, `empty` = 1.
  - `afull` = 0 unless AFULL_LEVEL is 0. `aempty` = 1.
  - `rdata` is don't-care while `rvld` = 0. For REG_OUT=1 it resets to 0.
  - Asserting reset mid-operation discards all data.
- **Memory:** the storage array is not reset. No data value is visible unless `rvld` = 1.

## Timing
- **Write-to-`rvld` latency from an empty FIFO:**
  - REG_OUT=0: 1 cycle. A write accepted at edge N gives `rvld` = 1 after edge N.
  - REG_OUT=1: 2 cycles, one for the memory write and one for the output load.
- **Throughput:** one write and one read per cycle sustained in both modes, with no bubbles when the FIFO is non-empty.
- **Status update:** `level` and the flags update on the edge after the handshake.
- **Wrap-around:** pointer wrap past DEPTH is seamless. Full and empty remain correct across the MSB toggle.
- **Combinational paths:** there is no combinational path from `wvld` or `rrdy` to any output.

## Structure
- No shared package. All constants are local parameters: DEPTH, CAP = DEPTH + REG_OUT, and LW.
- No sub-module. The storage array, pointer logic and output stage are small enough to stay in one module under 200 lines.
- Elaboration-time checks:
  - AFULL_LEVEL ≤ CAP.
  - AEMPTY_LEVEL < CAP.

## Test plan
- **Reset then fill:** release reset, then write 4 words 0x11–0x14 back-to-back with LOG_DEPTH=2 and REG_OUT=0.
  - `wrdy` drops after the 4th write.
  - `level` = 4, `full` = 1, `afull` set from level 3.
  - A 5th `wvld` is not accepted.
- **Drain order:** from full, hold `rrdy` = 1. Reads return 0x11, 0x12, 0x13, 0x14 on consecutive cycles, then `rvld` = 0 and `empty` = 1.
- **Simultaneous write and read at level 2 over 20 cycles:**
  - `level` stays 2.
  - Pointers wrap at least twice.
  - Data order is preserved.
- **REG_OUT=1 capacity and latency:**
  - A write at cycle 0 gives `rvld` at cycle 2.
  - Five writes with `rrdy` = 0 are accepted, then `full` = 1 and `level` = 5.
- **Flush:** at level 3, pulse `flush` together with `wvld`.
  - Next cycle: `level` = 0, `empty` = 1, `rvld` = 0.
  - The concurrent write is discarded.
- **Random soak:** random `wvld`/`rrdy` over 10k cycles against a reference queue model.
  - No loss, duplication or reordering.
  - `level` always equals the model count.

Source files
------------

// File: rtl/hazard3_sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides, fill level, threshold flags,
// synchronous flush and an optional registered head stage.
module hazard3_sync_fifo #(
  parameter int WIDTH        = 8,
  parameter int LOG_DEPTH    = 2,
  parameter int REG_OUT      = 0,
  parameter int AFULL_LEVEL  = (2 ** LOG_DEPTH) - 1,
  parameter int AEMPTY_LEVEL = 1,
  localparam int DEPTH       = 2 ** LOG_DEPTH,
  localparam int CAP         = DEPTH + REG_OUT,
  localparam int LW          = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wvld,
  output logic             wrdy,
  output logic [WIDTH-1:0] rdata,
  output logic             rvld,
  input  logic             rrdy,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             aempty
);

  localparam int PW = LOG_DEPTH + 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be at least 1");
  end
  if (LOG_DEPTH < 1) begin : g_bad_depth
    $error("LOG_DEPTH must be at least 1");
  end
  if (AFULL_LEVEL > CAP) begin : g_bad_afull
    $error("AFULL_LEVEL must not exceed the FIFO capacity");
  end
  if (AEMPTY_LEVEL >= CAP) begin : g_bad_aempty
    $error("AEMPTY_LEVEL must be below the FIFO capacity");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic mem_empty, mem_full;
  logic push, pop, load, mem_pop;

  // Pointers carry one wrap bit above the index so full and empty stay distinct.
  assign mem_empty = (wptr_q == rptr_q);
  assign mem_full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                     (wptr_q[PW-2:0] == rptr_q[PW-2:0]);

  assign level  = level_q;
  assign full   = (level_q == LW'(CAP));
  assign empty  = (level_q == '0);
  assign afull  = (level_q >= LW'(AFULL_LEVEL));
  assign aempty = (level_q <= LW'(AEMPTY_LEVEL));

  always_comb begin
    wrdy    = !full && !mem_full;
    rvld    = !mem_empty;
    rdata   = mem_q[rptr_q[PW-2:0]];
    if (REG_OUT != 0) begin
      rvld  = ov_q;
      rdata = rdata_q;
    end

    push    = wvld && wrdy;
    pop     = rvld && rrdy;
    // The head register refills in the same cycle its word is accepted.
    load    = (REG_OUT != 0) && !mem_empty && (!ov_q || pop);
    mem_pop = (REG_OUT != 0) ? load : pop;

    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(mem_pop);
    level_d = level_q + LW'(push) - LW'(pop);
    ov_d    = ov_q;
    rdata_d = rdata_q;

    if (load) begin
      ov_d    = 1'b1;
      rdata_d = mem_q[rptr_q[PW-2:0]];
    end else if (pop) begin
      ov_d    = 1'b0;
    end

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ov_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ov_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ov_q    <= ov_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately left unreset; nothing reads it unless rvld is high.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wptr_q[PW-2:0]] <= wdata;
    end
  end

endmodule

// File: tb/tb_hazard3_sync_fifo.sv
// Bench for hazard3_sync_fifo: one instance without and one with the output
// register, directed vector table, hand sequences and a queue-model soak.
module tb_hazard3_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] flush, wvld, rrdy;
  logic [1:0] wrdy, rvld, full, empty, afull, aempty;
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];
  logic [2:0] level [2];

  hazard3_sync_fifo #(.WIDTH(8), .LOG_DEPTH(2), .REG_OUT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]), .wdata(wdata[0]), .wvld(wvld[0]),
    .wrdy(wrdy[0]), .rdata(rdata[0]), .rvld(rvld[0]), .rrdy(rrdy[0]), .level(level[0]),
    .full(full[0]), .empty(empty[0]), .afull(afull[0]), .aempty(aempty[0])
  );

  hazard3_sync_fifo #(.WIDTH(8), .LOG_DEPTH(2), .REG_OUT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]), .wdata(wdata[1]), .wvld(wvld[1]),
    .wrdy(wrdy[1]), .rdata(rdata[1]), .rvld(rvld[1]), .rrdy(rrdy[1]), .level(level[1]),
    .full(full[1]), .empty(empty[1]), .afull(afull[1]), .aempty(aempty[1])
  );

  typedef struct {
    logic       flush;
    logic       wvld;
    logic [7:0] wdata;
    logic       rrdy;
    logic [2:0] e_level;
    logic       e_wrdy;
    logic       e_rvld;
    logic [7:0] e_rdata;
    logic       e_full;
    logic       e_empty;
    logic       e_afull;
    logic       e_aempty;
  } vec_t;

  vec_t       vecs [9];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];
  int         ts_q  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int d, input logic f, input logic wv, input logic [7:0] wd,
                       input logic rr);
    flush[d] = f;
    wvld[d]  = wv;
    wdata[d] = wd;
    rrdy[d]  = rr;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_status(input int d, input int lvl, input logic wr, input logic rv,
                              input logic fu, input logic em, input logic af, input logic ae);
    check($sformatf("dut%0d_level", d), 32'(level[d]), 32'(lvl));
    check($sformatf("dut%0d_wrdy", d), 32'(wrdy[d]), 32'(wr));
    check($sformatf("dut%0d_rvld", d), 32'(rvld[d]), 32'(rv));
    check($sformatf("dut%0d_full", d), 32'(full[d]), 32'(fu));
    check($sformatf("dut%0d_empty", d), 32'(empty[d]), 32'(em));
    check($sformatf("dut%0d_afull", d), 32'(afull[d]), 32'(af));
    check($sformatf("dut%0d_aempty", d), 32'(aempty[d]), 32'(ae));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Reference: a plain queue with capacity cap. An entry written at edge w is
  // visible at the head after edge k once k - w >= lat (lat = 1 with output register).
  task automatic soak(input int d, input int cycles);
    int   cap, lat, k, lvl;
    logic vis, f, wv, rr, acc_w, acc_r;
    logic [7:0] wd;
    cap = (d == 1) ? 5 : 4;
    lat = d;
    k   = 0;
    exp_q.delete();
    ts_q.delete();
    for (int c = 0; c < cycles; c++) begin
      lvl = exp_q.size();
      vis = (lvl > 0) && ((k - ts_q[0]) >= lat);
      check_status(d, lvl, lvl < cap, vis, lvl == cap, lvl == 0, lvl >= 3, lvl <= 1);
      if (vis) check($sformatf("soak%0d_rdata", d), 32'(rdata[d]), 32'(exp_q[0]));
      f  = ($urandom_range(0, 99) == 0);
      wv = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) != 0) ^ (c[9] & d[0]);
      wd = 8'($urandom);
      drive(d, f, wv, wd, rr);
      acc_w = wv && (lvl < cap);
      acc_r = rr && vis;
      @(posedge clk);
      k++;
      if (f) begin
        exp_q.delete();
        ts_q.delete();
      end else begin
        if (acc_r) begin
          void'(exp_q.pop_front());
          void'(ts_q.pop_front());
        end
        if (acc_w) begin
          exp_q.push_back(wd);
          ts_q.push_back(k);
        end
      end
      #1;
    end
    idle_all();
  endtask

  initial begin
    logic [7:0] v;
    vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 8'h12, 1'b0, 3'd2, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h13, 1'b0, 3'd3, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h14, 1'b0, 3'd4, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h15, 1'b0, 3'd4, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    idle_all();
    #12;
    check_status(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_status(1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("reset_rdata_reg", 32'(rdata[1]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill to full, reject a fifth write, then drain in order.
    for (int i = 0; i < 9; i++) begin
      drive(0, vecs[i].flush, vecs[i].wvld, vecs[i].wdata, vecs[i].rrdy);
      tick();
      check_status(0, int'(vecs[i].e_level), vecs[i].e_wrdy, vecs[i].e_rvld, vecs[i].e_full,
                   vecs[i].e_empty, vecs[i].e_afull, vecs[i].e_aempty);
      if (vecs[i].e_rvld) check($sformatf("vec%0d_rdata", i), 32'(rdata[0]), 32'(vecs[i].e_rdata));
    end
    idle_all();

    // Two entries in flight, then 20 cycles of simultaneous write and read.
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      v = 8'(8'hA0 + i);
      drive(0, 1'b0, 1'b1, v, 1'b0);
      tick();
      exp_q.push_back(v);
    end
    for (int i = 0; i < 20; i++) begin
      v = 8'(8'hB0 + i);
      drive(0, 1'b0, 1'b1, v, 1'b1);
      check("simul_rvld", 32'(rvld[0]), 32'h1);
      check("simul_rdata", 32'(rdata[0]), 32'(exp_q[0]));
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(v);
      check("simul_level", 32'(level[0]), 32'd2);
    end

    // Flush at level 3 with a concurrent write.
    drive(0, 1'b0, 1'b1, 8'hC0, 1'b0);
    tick();
    check("pre_flush_level", 32'(level[0]), 32'd3);
    drive(0, 1'b1, 1'b1, 8'h77, 1'b0);
    tick();
    idle_all();
    check_status(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check_status(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Registered output: two-cycle latency and capacity of five.
    drive(1, 1'b0, 1'b1, 8'h31, 1'b0);
    tick();
    check("reg_lat_rvld_c1", 32'(rvld[1]), 32'h0);
    check("reg_lat_level_c1", 32'(level[1]), 32'd1);
    for (int i = 1; i < 5; i++) begin
      drive(1, 1'b0, 1'b1, 8'(8'h31 + i), 1'b0);
      tick();
      check("reg_head_rvld", 32'(rvld[1]), 32'h1);
      check("reg_head_rdata", 32'(rdata[1]), 32'h31);
    end
    check_status(1, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1, 1'b0, 1'b1, 8'h36, 1'b0);
    tick();
    check("reg_full_level", 32'(level[1]), 32'd5);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b0, 1'b0, 8'h00, 1'b1);
      check("reg_drain_rvld", 32'(rvld[1]), 32'h1);
      check("reg_drain_rdata", 32'(rdata[1]), 32'(8'h31 + i));
      tick();
    end
    idle_all();
    check_status(1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    do_reset();
    soak(0, 5000);
    do_reset();
    soak(1, 5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
